// File: rtl/factor_pkg.sv
// Shared types and constants for the factorization game question judge.
package factor_pkg;

    // Judge controller states, in the order a question normally walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT1,
        ST_LOAD,
        ST_INPUT,
        ST_JUDGE,
        ST_RESULT,
        ST_DONE
    } state_e;

    // Field positions inside the 24-bit ROM question word.
    localparam int QUE_MSB = 23;
    localparam int QUE_LSB = 12;
    localparam int ANS_MSB = 11;
    localparam int ANS_LSB = 0;

    // Each answer is three 4-bit codes.
    localparam int ANS_W   = 4;
    localparam int ANS_CNT = 3;

    // Score increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/answer_match.sv
// Order-insensitive comparison of three entered codes against three answer codes.
module answer_match
    import factor_pkg::*;
(
    input  logic [ANS_CNT*ANS_W-1:0] entries_i,
    input  logic [ANS_CNT*ANS_W-1:0] answers_i,
    output logic                     match_o
);

    logic [ANS_CNT-1:0] used;
    logic               found;

    // Greedily pair each entry with the first unused equal answer slot; any unpaired entry fails.
    always_comb begin
        used    = '0;
        found   = 1'b0;
        match_o = 1'b1;
        for (int i = 0; i < ANS_CNT; i++) begin
            found = 1'b0;
            for (int j = 0; j < ANS_CNT; j++) begin
                if (!found && !used[j] &&
                    (entries_i[i*ANS_W +: ANS_W] == answers_i[j*ANS_W +: ANS_W])) begin
                    used[j] = 1'b1;
                    found   = 1'b1;
                end
            end
            if (!found) begin
                match_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/factor_quiz_judge.sv
// Question ROM consumer: fetches each question, collects three keypad codes,
// judges them and keeps the score for one game of NUM_Q questions.
module factor_quiz_judge
    import factor_pkg::*;
#(
    parameter int unsigned NUM_Q          = 10,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned RESULT_CYCLES  = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    output logic [3:0]  num_in_o,
    input  logic [23:0] question_i,
    output logic [11:0] que_digits_o,
    output logic [1:0]  entry_cnt_o,
    output logic        correct_o,
    output logic        wrong_o,
    output logic [3:0]  score_o,
    output logic        busy_o,
    output logic        game_over_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RES_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_CYCLES - 1);
    localparam logic [3:0]       Q_LAST   = 4'(NUM_Q);

    state_e state_q, state_d;

    logic [3:0]             qIdx_q, qIdx_d;
    logic [3:0]             numIn_q, numIn_d;
    logic [11:0]            queDigits_q, queDigits_d;
    logic [11:0]            answer_q, answer_d;
    logic [11:0]            entry_q, entry_d;
    logic [1:0]             entryCnt_q, entryCnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [RES_W-1:0]       res_q, res_d;
    logic                   correct_q, correct_d;
    logic                   wrong_q, wrong_d;
    logic [3:0]             score_q, score_d;

    logic keyAccept;
    logic thirdKey;
    logic tmoExpired;
    logic resDone;
    logic lastQ;
    logic match;

    assign keyAccept  = (state_q == ST_INPUT) && key_valid_i;
    assign thirdKey   = keyAccept && (entryCnt_q == 2'd2);
    assign tmoExpired = (tmo_q == TMO_LAST);
    assign resDone    = (res_q == RES_LAST);
    assign lastQ      = (qIdx_q == Q_LAST);

    answer_match u_answer_match (
        .entries_i (entry_q),
        .answers_i (answer_q),
        .match_o   (match)
    );

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a third key on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_REQ;
            ST_REQ:           state_d = ST_WAIT1;
            ST_WAIT1:         state_d = ST_LOAD;
            ST_LOAD:          state_d = ST_INPUT;
            ST_INPUT: begin
                if (thirdKey) begin
                    state_d = ST_JUDGE;
                end else if (tmoExpired) begin
                    state_d = ST_RESULT;
                end
            end
            ST_JUDGE:         state_d = ST_RESULT;
            ST_RESULT: begin
                if (resDone) begin
                    state_d = lastQ ? ST_DONE : ST_REQ;
                end
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: question fetch, key capture, timers, verdict and score.
    always_comb begin
        qIdx_d      = qIdx_q;
        numIn_d     = numIn_q;
        queDigits_d = queDigits_q;
        answer_d    = answer_q;
        entry_d     = entry_q;
        entryCnt_d  = entryCnt_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        correct_d   = correct_q;
        wrong_d     = wrong_q;
        score_d     = score_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    score_d = 4'd0;
                    qIdx_d  = 4'd1;
                end
            end
            ST_REQ: begin
                numIn_d    = qIdx_q;
                entryCnt_d = 2'd0;
                tmo_d      = '0;
            end
            ST_LOAD: begin
                queDigits_d = question_i[QUE_MSB:QUE_LSB];
                answer_d    = question_i[ANS_MSB:ANS_LSB];
            end
            ST_INPUT: begin
                tmo_d = tmo_q + TMO_W'(1);
                res_d = '0;
                if (keyAccept) begin
                    case (entryCnt_q)
                        2'd0:    entry_d[11:8] = key_code_i;
                        2'd1:    entry_d[7:4]  = key_code_i;
                        default: entry_d[3:0]  = key_code_i;
                    endcase
                    entryCnt_d = entryCnt_q + 2'd1;
                end
                if (!thirdKey && tmoExpired) begin
                    wrong_d = 1'b1;
                end
            end
            ST_JUDGE: begin
                res_d = '0;
                if (match) begin
                    correct_d = 1'b1;
                    score_d   = satInc(score_q);
                end else begin
                    wrong_d = 1'b1;
                end
            end
            ST_RESULT: begin
                res_d = res_q + RES_W'(1);
                if (resDone) begin
                    res_d     = '0;
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    if (lastQ) begin
                        numIn_d = 4'd0;
                    end else begin
                        qIdx_d = qIdx_q + 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset abandons any game in progress without a verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qIdx_q      <= 4'd1;
            numIn_q     <= 4'd0;
            queDigits_q <= 12'd0;
            answer_q    <= 12'd0;
            entry_q     <= 12'd0;
            entryCnt_q  <= 2'd0;
            tmo_q       <= '0;
            res_q       <= '0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            score_q     <= 4'd0;
        end else begin
            qIdx_q      <= qIdx_d;
            numIn_q     <= numIn_d;
            queDigits_q <= queDigits_d;
            answer_q    <= answer_d;
            entry_q     <= entry_d;
            entryCnt_q  <= entryCnt_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            correct_q   <= correct_d;
            wrong_q     <= wrong_d;
            score_q     <= score_d;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_o      = !((state_q == ST_IDLE) || (state_q == ST_DONE));
        game_over_o = (state_q == ST_DONE);
    end

    assign num_in_o     = numIn_q;
    assign que_digits_o = queDigits_q;
    assign entry_cnt_o  = entryCnt_q;
    assign correct_o    = correct_q;
    assign wrong_o      = wrong_q;
    assign score_o      = score_q;

endmodule

// File: tb/tb_factor_quiz_judge.sv
// Scoreboard bench for factor_quiz_judge with a small registered question ROM.
module tb_factor_quiz_judge;

    localparam int NQ  = 3;
    localparam int TMO = 20;
    localparam int RES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        keyValid = 1'b0;
    logic [3:0]  keyCode = 4'd0;
    logic [3:0]  numIn;
    logic [23:0] question = 24'd0;
    logic [11:0] queDigits;
    logic [1:0]  entryCnt;
    logic        correct;
    logic        wrong;
    logic [3:0]  score;
    logic        busy;
    logic        gameOver;

    typedef struct {
        logic       correct;
        logic       wrong;
        logic [3:0] score;
    } result_t;

    result_t sbQ[$];
    result_t expRes;
    int      checkCount = 0;
    int      passCount  = 0;
    logic    prevC = 1'b0;
    logic    prevW = 1'b0;
    int      pulseLen = 0;

    factor_quiz_judge #(
        .NUM_Q          (NQ),
        .TIMEOUT_CYCLES (TMO),
        .RESULT_CYCLES  (RES)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .key_valid_i  (keyValid),
        .key_code_i   (keyCode),
        .num_in_o     (numIn),
        .question_i   (question),
        .que_digits_o (queDigits),
        .entry_cnt_o  (entryCnt),
        .correct_o    (correct),
        .wrong_o      (wrong),
        .score_o      (score),
        .busy_o       (busy),
        .game_over_o  (gameOver)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [23:0] romWord(input logic [3:0] idx);
        case (idx)
            4'd1:    return 24'h027_222;
            4'd2:    return 24'h042_124;
            4'd3:    return 24'h135_357;
            default: return 24'h000_000;
        endcase
    endfunction

    // Question ROM with a one-cycle registered read.
    always @(posedge clk) question <= romWord(numIn);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        keyValid = 1'b1;
        keyCode  = code;
        tick();
        keyValid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pushExpect(input logic c, input logic w, input logic [3:0] s);
        result_t r;
        r.correct = c;
        r.wrong   = w;
        r.score   = s;
        sbQ.push_back(r);
    endtask

    task automatic waitNumIn(input logic [3:0] v);
        for (int i = 0; i < 100 && numIn !== v; i++) tick();
        checkOutput("numIn", {28'd0, numIn}, {28'd0, v});
    endtask

    task automatic waitGameOver();
        for (int i = 0; i < 100 && gameOver !== 1'b1; i++) tick();
        checkOutput("gameOver", {31'd0, gameOver}, 32'd1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstNumIn", {28'd0, numIn}, 32'd0);
        checkOutput("rstQueDigits", {20'd0, queDigits}, 32'd0);
        checkOutput("rstEntryCnt", {30'd0, entryCnt}, 32'd0);
        checkOutput("rstCorrect", {31'd0, correct}, 32'd0);
        checkOutput("rstWrong", {31'd0, wrong}, 32'd0);
        checkOutput("rstScore", {28'd0, score}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstGameOver", {31'd0, gameOver}, 32'd0);
    endtask

    // Monitor: on each new verdict pop the expected result; also check pulse width.
    always @(negedge clk) begin
        if (rst) begin
            prevC    = 1'b0;
            prevW    = 1'b0;
            pulseLen = 0;
        end else begin
            if ((correct || wrong) && !(prevC || prevW)) begin
                checkOutput("resultExclusive", {31'd0, correct & wrong}, 32'd0);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedResult", {30'd0, correct, wrong}, 32'd0);
                end else begin
                    expRes = sbQ.pop_front();
                    checkOutput("resultCorrect", {31'd0, correct}, {31'd0, expRes.correct});
                    checkOutput("resultWrong", {31'd0, wrong}, {31'd0, expRes.wrong});
                    checkOutput("resultScore", {28'd0, score}, {28'd0, expRes.score});
                end
                pulseLen = 1;
            end else if (correct || wrong) begin
                pulseLen++;
            end else if (prevC || prevW) begin
                checkOutput("pulseLength", pulseLen, RES);
            end
            prevC = correct;
            prevW = wrong;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus: two full games, then a reset in the middle of a third.
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        checkResetOutputs();

        applyStimulus(4'd5);
        checkOutput("idleKeyIgnored", {30'd0, entryCnt}, 32'd0);

        // Game 1
        pulseStart();
        checkOutput("numInInReq", {28'd0, numIn}, 32'd0);
        tick();
        checkOutput("numInAfterReq", {28'd0, numIn}, 32'd1);
        checkOutput("busyInGame", {31'd0, busy}, 32'd1);
        applyStimulus(4'd9);
        checkOutput("loadKeyIgnored", {30'd0, entryCnt}, 32'd0);
        checkOutput("queDigitsNotYet", {20'd0, queDigits}, 32'd0);
        tick();
        checkOutput("queDigitsQ1", {20'd0, queDigits}, 32'h027);
        pushExpect(1'b0, 1'b1, 4'd0);
        applyStimulus(4'd2);
        applyStimulus(4'd2);
        applyStimulus(4'd3);

        waitNumIn(4'd2);
        applyStimulus(4'd9);
        tick();
        checkOutput("queDigitsQ2", {20'd0, queDigits}, 32'h042);
        pushExpect(1'b1, 1'b0, 4'd1);
        applyStimulus(4'd4);
        applyStimulus(4'd1);
        applyStimulus(4'd2);

        waitNumIn(4'd3);
        tick();
        tick();
        checkOutput("queDigitsQ3", {20'd0, queDigits}, 32'h135);
        pushExpect(1'b0, 1'b1, 4'd1);
        applyStimulus(4'd3);
        applyStimulus(4'd5);
        repeat (17) tick();
        checkOutput("wrongBeforeExpiry", {31'd0, wrong}, 32'd0);
        tick();
        checkOutput("wrongAtExpiry", {31'd0, wrong}, 32'd1);

        waitGameOver();
        checkOutput("game1Score", {28'd0, score}, 32'd1);
        checkOutput("game1NumIn", {28'd0, numIn}, 32'd0);
        checkOutput("game1Busy", {31'd0, busy}, 32'd0);
        checkOutput("game1QueHeld", {20'd0, queDigits}, 32'h135);

        // Game 2
        pulseStart();
        checkOutput("game2ScoreCleared", {28'd0, score}, 32'd0);
        checkOutput("game2GameOverClr", {31'd0, gameOver}, 32'd0);
        waitNumIn(4'd1);
        tick();
        tick();
        pushExpect(1'b1, 1'b0, 4'd1);
        applyStimulus(4'd2);
        applyStimulus(4'd2);
        repeat (17) tick();
        applyStimulus(4'd2);
        checkOutput("expiryKeyEntryCnt", {30'd0, entryCnt}, 32'd3);
        checkOutput("expiryKeyNoWrong", {31'd0, wrong}, 32'd0);

        waitNumIn(4'd2);
        tick();
        tick();
        pushExpect(1'b1, 1'b0, 4'd2);
        applyStimulus(4'd2);
        applyStimulus(4'd4);
        applyStimulus(4'd1);

        waitNumIn(4'd3);
        tick();
        tick();
        pushExpect(1'b1, 1'b0, 4'd3);
        applyStimulus(4'd7);
        applyStimulus(4'd3);
        applyStimulus(4'd5);

        waitGameOver();
        checkOutput("game2Score", {28'd0, score}, 32'd3);
        checkOutput("game2NumIn", {28'd0, numIn}, 32'd0);

        // Game 3, aborted by reset mid-entry
        pulseStart();
        checkOutput("game3ScoreCleared", {28'd0, score}, 32'd0);
        waitNumIn(4'd1);
        tick();
        tick();
        applyStimulus(4'd3);
        applyStimulus(4'd3);
        checkOutput("twoKeysEntered", {30'd0, entryCnt}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetOutputs();
        repeat (10) tick();
        checkOutput("idleAfterReset", {31'd0, busy}, 32'd0);
        checkOutput("pendingResults", sbQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
